// File: rtl/hazard_scoreboard.sv
// Decode-side hazard tracker: follows producers through the forwarding stages and
// drives stall plus registered one-hot bypass selects for the EX operand muxes.

module hs_stage_match #(
    parameter int ADDR_W = 4
) (
    input  logic              v,
    input  logic              we,
    input  logic [ADDR_W-1:0] dst,
    input  logic              kill,
    input  logic              re0,
    input  logic [ADDR_W-1:0] p0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] p1,
    output logic              m0,
    output logic              m1
);
    logic wr;

    // R0 is hardwired zero, so a dst=0 writer never forwards
    assign wr = v & we & !kill & (dst != '0);
    assign m0 = wr & re0 & (dst == p0);
    assign m1 = wr & re1 & (dst == p1);
endmodule

module hazard_scoreboard #(
    parameter  int NUM_REGS   = 16,
    parameter  int BYP_STAGES = 2,
    parameter  int MC_W       = 3,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_re0,
    input  logic                  id_re1,
    input  logic [ADDR_W-1:0]     id_p0_addr,
    input  logic [ADDR_W-1:0]     id_p1_addr,
    input  logic                  id_we,
    input  logic [ADDR_W-1:0]     id_dst_addr,
    input  logic                  id_is_load,
    input  logic [MC_W-1:0]       id_mc_cycles,
    input  logic                  flush,
    input  logic                  ex_we_kill,
    output logic                  stall,
    output logic [BYP_STAGES-1:0] byp0,
    output logic [BYP_STAGES-1:0] byp1,
    output logic                  retire_we,
    output logic [ADDR_W-1:0]     retire_dst
);
    typedef struct packed {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] dst;
        logic              ld;
    } entry_t;

    entry_t [BYP_STAGES-1:0] stg;
    entry_t                  id_ent;
    entry_t                  s1_ent;
    logic   [MC_W-1:0]       mc_cnt;
    logic   [BYP_STAGES-1:0] m0, m1;
    logic                    mc_busy, load_use, issue;

    for (genvar k = 0; k < BYP_STAGES; k++) begin : g_match
        hs_stage_match #(.ADDR_W(ADDR_W)) u_match (
            .v    (stg[k].v),
            .we   (stg[k].we),
            .dst  (stg[k].dst),
            .kill ((k == 0) ? ex_we_kill : 1'b0),
            .re0  (id_re0),
            .p0   (id_p0_addr),
            .re1  (id_re1),
            .p1   (id_p1_addr),
            .m0   (m0[k]),
            .m1   (m1[k])
        );
    end

    assign mc_busy  = (mc_cnt != '0);
    assign load_use = stg[0].ld & (m0[0] | m1[0]);
    assign stall    = mc_busy | (id_valid & load_use);
    assign issue    = id_valid & !stall & !flush;

    always_comb begin
        id_ent     = '0;
        id_ent.v   = issue;
        id_ent.we  = id_we & issue;
        id_ent.dst = id_dst_addr;
        id_ent.ld  = id_is_load;
        s1_ent     = stg[0];
        s1_ent.we  = stg[0].we & !ex_we_kill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg    <= '0;
            mc_cnt <= '0;
            byp0   <= '0;
            byp1   <= '0;
        end else begin
            // isolate lowest set bit: youngest matching producer wins
            byp0 <= m0 & (~m0 + 1'b1);
            byp1 <= m1 & (~m1 + 1'b1);
            for (int k = 2; k < BYP_STAGES; k++)
                stg[k] <= stg[k-1];
            if (mc_busy) begin
                // multi-cycle op parks in stage 0; bubbles drain behind it
                stg[1] <= '0;
                mc_cnt <= mc_cnt - 1'b1;
            end else begin
                stg[0] <= id_ent;
                stg[1] <= s1_ent;
                if (issue)
                    mc_cnt <= id_mc_cycles;
            end
        end
    end

    assign retire_we  = stg[BYP_STAGES-1].v & stg[BYP_STAGES-1].we;
    assign retire_dst = stg[BYP_STAGES-1].dst;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus queues per-cycle expectations, a negedge monitor pops
// and compares them against the DUT outputs.

module tb_hazard_scoreboard;
    localparam int M_ST = 1, M_B0 = 2, M_B1 = 4, M_RW = 8, M_RD = 16, M_ALL = 31;

    logic       clk, rst;
    logic       id_valid, id_re0, id_re1, id_we, id_is_load, flush, ex_we_kill;
    logic [3:0] id_p0_addr, id_p1_addr, id_dst_addr;
    logic [2:0] id_mc_cycles;
    logic       stall, retire_we;
    logic [1:0] byp0, byp1;
    logic [3:0] retire_dst;

    hazard_scoreboard #(.NUM_REGS(16), .BYP_STAGES(2), .MC_W(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_re0(id_re0), .id_re1(id_re1),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr), .id_we(id_we),
        .id_dst_addr(id_dst_addr), .id_is_load(id_is_load), .id_mc_cycles(id_mc_cycles),
        .flush(flush), .ex_we_kill(ex_we_kill), .stall(stall), .byp0(byp0), .byp1(byp1),
        .retire_we(retire_we), .retire_dst(retire_dst)
    );

    typedef struct {
        int         cyc;
        string      nm;
        int         mask;
        logic       st;
        logic [1:0] b0, b1;
        logic       rwe;
        logic [3:0] rdst;
    } exp_t;

    exp_t exq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s cycle %0d: got %0h expected %0h", nm, fld, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = exq.size() - 1; i >= 0; i--) begin
            if (exq[i].cyc == cyc) begin
                if (exq[i].mask & M_ST) cmp(exq[i].nm, "stall", 32'(stall), 32'(exq[i].st));
                if (exq[i].mask & M_B0) cmp(exq[i].nm, "byp0", 32'(byp0), 32'(exq[i].b0));
                if (exq[i].mask & M_B1) cmp(exq[i].nm, "byp1", 32'(byp1), 32'(exq[i].b1));
                if (exq[i].mask & M_RW) cmp(exq[i].nm, "retire_we", 32'(retire_we), 32'(exq[i].rwe));
                if (exq[i].mask & M_RD) cmp(exq[i].nm, "retire_dst", 32'(retire_dst), 32'(exq[i].rdst));
                exq.delete(i);
            end
        end
    end

    function automatic void ex(string nm, int dc, int mask, logic st, logic [1:0] b0,
                               logic [1:0] b1, logic rwe, logic [3:0] rdst);
        exp_t e;
        e.cyc = cyc + dc; e.nm = nm; e.mask = mask; e.st = st;
        e.b0 = b0; e.b1 = b1; e.rwe = rwe; e.rdst = rdst;
        exq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; id_re0 = 0; id_re1 = 0; id_we = 0; id_is_load = 0;
        id_p0_addr = 0; id_p1_addr = 0; id_dst_addr = 0; id_mc_cycles = 0;
        flush = 0; ex_we_kill = 0;
    endtask

    task automatic drv(logic we, logic [3:0] dst, logic ld, logic [2:0] mc,
                       logic re0, logic [3:0] p0, logic re1, logic [3:0] p1);
        id_valid = 1; id_we = we; id_dst_addr = dst; id_is_load = ld; id_mc_cycles = mc;
        id_re0 = re0; id_p0_addr = p0; id_re1 = re1; id_p1_addr = p1;
    endtask

    task automatic drain();
        idle_in();
        repeat (2) tick();
    endtask

    initial begin
        idle_in();
        rst = 1;
        repeat (2) tick();
        rst = 0;

        // reset state and idle
        for (int i = 0; i < 4; i++) begin
            ex("reset_idle", 0, M_ALL, 0, 2'b00, 2'b00, 0, 4'd0);
            tick();
        end

        // forwarding distance 1, 2, then out of range
        drv(1, 4'd3, 0, 0, 0, 0, 0, 0);
        ex("fwd_wr", 0, M_ST, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd3, 0, 0);
        ex("fwd_s0", 0, M_ST, 0, 0, 0, 0, 0);
        ex("fwd_s0", 1, M_B0, 0, 2'b01, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 0, 0, 1, 4'd3);
        ex("fwd_s1_ret", 0, M_RW | M_RD, 0, 0, 0, 1, 4'd3);
        ex("fwd_s1", 1, M_B1, 0, 0, 2'b10, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd3, 0, 0);
        ex("fwd_gone", 0, M_RW, 0, 0, 0, 0, 0);
        ex("fwd_gone", 1, M_B0, 0, 2'b00, 0, 0, 0);
        tick();
        drain();

        // load-use: one-cycle stall, then bypass from stage 1
        drv(1, 4'd5, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 0, 0, 1, 4'd5);
        ex("lu_stall", 0, M_ST, 1, 0, 0, 0, 0);
        tick();
        ex("lu_release", 0, M_ST, 0, 0, 0, 0, 0);
        ex("lu_release", 1, M_B1, 0, 0, 2'b10, 0, 0);
        tick();
        drain();
        drv(1, 4'd6, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd2, 1, 4'd9);
        ex("lu_nodep", 0, M_ST, 0, 0, 0, 0, 0);
        ex("lu_nodep", 1, M_B0 | M_B1, 0, 2'b00, 2'b00, 0, 0);
        tick();
        drain();

        // multi-cycle op with 3 extra cycles, dependent reader waiting in ID
        drv(1, 4'd7, 0, 3'd3, 0, 0, 0, 0);
        ex("mc_issue", 0, M_ST, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ex("mc_stall", 0, M_ST | M_RW, 1, 0, 0, 0, 0);
            tick();
        end
        ex("mc_done", 0, M_ST, 0, 0, 0, 0, 0);
        ex("mc_fwd", 1, M_B0 | M_RW | M_RD, 0, 2'b01, 0, 1, 4'd7);
        tick();
        drain();

        // killed write in stage 0 falls through to the older producer
        drv(1, 4'd4, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd4, 0, 0);
        ex_we_kill = 1;
        ex("kill_ret_old", 0, M_RW | M_RD, 0, 0, 0, 1, 4'd4);
        ex("kill_fwd", 1, M_B0 | M_RW, 0, 2'b10, 0, 0, 0);
        tick();
        drain();

        // R0 writer never forwards nor causes load-use
        drv(1, 4'd0, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd0, 0, 0);
        ex("r0_nostall", 0, M_ST, 0, 0, 0, 0, 0);
        ex("r0_nofwd", 1, M_B0, 0, 2'b00, 0, 0, 0);
        tick();
        drain();

        // flush during load-use stall, then flush of a plain writer
        drv(1, 4'd5, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, 4'd1, 0, 0, 1, 4'd5, 0, 0);
        flush = 1;
        ex("flush_lu", 0, M_ST, 1, 0, 0, 0, 0);
        tick();
        flush = 0;
        ex("flush_after", 0, M_ST | M_RW | M_RD, 0, 0, 0, 1, 4'd5);
        ex("flush_after", 1, M_B0, 0, 2'b10, 0, 0, 0);
        tick();
        drain();
        drv(1, 4'd8, 0, 0, 0, 0, 0, 0);
        flush = 1;
        tick();
        flush = 0;
        drv(0, 4'd1, 0, 0, 1, 4'd8, 0, 0);
        ex("flush_wr", 1, M_B0 | M_RW, 0, 2'b00, 0, 0, 0);
        tick();
        drain();

        // reset in the middle of a multi-cycle op abandons it
        drv(1, 4'd9, 0, 3'd3, 0, 0, 0, 0);
        tick();
        idle_in();
        ex("mcr_busy3", 0, M_ST, 1, 0, 0, 0, 0);
        tick();
        rst = 1;
        ex("mcr_busy2", 0, M_ST, 1, 0, 0, 0, 0);
        tick();
        rst = 0;
        ex("mcr_cleared", 0, M_ALL, 0, 2'b00, 2'b00, 0, 4'd0);
        drv(0, 4'd1, 0, 0, 1, 4'd9, 0, 0);
        ex("mcr_nofwd", 1, M_ST | M_B0 | M_RW, 0, 2'b00, 0, 0, 0);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            ex("mcr_noretire", 0, M_ST | M_RW, 0, 0, 0, 0, 0);
            tick();
        end

        repeat (3) tick();
        while (exq.size() != 0) begin
            errors++;
            $display("FAIL unchecked_%s: expectation for cycle %0d never compared", exq[0].nm, exq[0].cyc);
            void'(exq.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
